// File: rtl/video_pkg.sv
// Shared video types and 1080p raster constants used by the fetch scheduler
// and the raster timing generator.
package video_pkg;

  // Fetch scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int unsigned H_VISIBLE_1080P = 1920;
  localparam int unsigned V_VISIBLE_1080P = 1080;
  localparam int unsigned H_TOTAL_1080P   = 2200;
  localparam int unsigned V_TOTAL_1080P   = 1125;

  // Counter width able to hold values 0..n-1 (at least one bit)
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sig_edge_det.sv
// Registers a level input once and produces one-cycle rise/fall pulses
// aligned with the cycle in which the registered level changes.
module sig_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;
  logic rise_q;
  logic fall_q;

  // Capture level and compare new sample against the held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
      fall_q <= ~sig_i & sig_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/line_fetch_scheduler.sv
// Frame-buffer line fetch scheduler feeding a ping-pong line buffer.
// Optional build macro: LFS_UNDERRUN_CNT_EN enables the saturating
// underrun event counter; otherwise underrun_cnt is tied to zero.
module line_fetch_scheduler
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = H_VISIBLE_1080P,
  parameter int unsigned V_VISIBLE       = V_VISIBLE_1080P,
  parameter int unsigned BURST_LEN       = 64,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              pixel_clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              vsync,
  input  logic              de,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_slot,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              frame_start,
  output logic              underrun,
  output logic [15:0]       underrun_cnt,
  output logic              busy
);

  localparam int unsigned BURSTS_PER_LINE = H_VISIBLE / BURST_LEN;
  localparam int unsigned BURST_W         = cnt_w(BURSTS_PER_LINE);
  localparam int unsigned LINE_W          = $clog2(V_VISIBLE + 1);
  localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * BYTES_PER_PIXEL);
  localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(BURSTS_PER_LINE - 1);
  localparam logic [LINE_W-1:0]  LINES       = LINE_W'(V_VISIBLE);

  fetch_state_e      state_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_slot_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [LINE_W-1:0] line_cnt_q;
  logic [1:0]        slots_ready_q;
  logic [1:0]        slots_free_q;
  logic              restart_pend_q;
  logic              frame_start_q;
  logic              underrun_q;
  logic              busy_q;

  logic vsync_fall;
  logic vsync_rise_unused;
  logic de_rise;
  logic de_fall;

  logic restart_c;
  logic start_c;
  logic line_done_c;
  logic underrun_evt_c;

  sig_edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
    .clk    (pixel_clock),
    .rst_n  (rst_n),
    .sig_i  (vsync),
    .rise_o (vsync_rise_unused),
    .fall_o (vsync_fall)
  );

  sig_edge_det #(.RST_VAL(1'b0)) u_de_edge (
    .clk    (pixel_clock),
    .rst_n  (rst_n),
    .sig_i  (de),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  // Per-cycle decisions shared by the FSM and the slot/flag bookkeeping
  always_comb begin
    restart_c      = (state_q == IDLE) && restart_pend_q;
    start_c        = (state_q == IDLE) && enable && !restart_pend_q &&
                     (line_cnt_q < LINES) && (slots_free_q != 2'd0);
    line_done_c    = (state_q == WAIT) && rd_done && !restart_pend_q &&
                     (burst_cnt_q == LAST_BURST);
    underrun_evt_c = de_rise && enable && (slots_ready_q == 2'd0);
  end

  // Burst request FSM with address/line/slot tracking; line_cnt resets to
  // "frame complete" so nothing is fetched before the first frame start
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_slot_q   <= 1'b0;
      addr_q      <= '0;
      burst_cnt_q <= '0;
      line_cnt_q  <= LINES;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (restart_c) begin
            line_cnt_q  <= '0;
            burst_cnt_q <= '0;
            addr_q      <= base_q;
            rd_slot_q   <= 1'b0;
          end else if (start_c) begin
            state_q   <= REQ;
            rd_req_q  <= 1'b1;
            rd_addr_q <= addr_q;
            busy_q    <= 1'b1;
          end
        end
        REQ: begin
          if (rd_ack) begin
            state_q  <= WAIT;
            rd_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (rd_done) begin
            addr_q <= addr_q + BURST_BYTES;
            if (restart_pend_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (burst_cnt_q == LAST_BURST) begin
              burst_cnt_q <= '0;
              line_cnt_q  <= line_cnt_q + LINE_W'(1);
              rd_slot_q   <= ~rd_slot_q;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end else begin
              burst_cnt_q <= burst_cnt_q + BURST_W'(1);
              if (enable) begin
                state_q   <= REQ;
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr_q + BURST_BYTES;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_req_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Ping-pong slot occupancy; simultaneous fill and drain cancel out
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      slots_ready_q <= 2'd0;
      slots_free_q  <= 2'd2;
    end else if (restart_c) begin
      slots_ready_q <= 2'd0;
      slots_free_q  <= 2'd2;
    end else if (line_done_c && !de_fall) begin
      slots_ready_q <= slots_ready_q + 2'd1;
      slots_free_q  <= slots_free_q - 2'd1;
    end else if (!line_done_c && de_fall) begin
      if (slots_ready_q != 2'd0) slots_ready_q <= slots_ready_q - 2'd1;
      if (slots_free_q != 2'd2)  slots_free_q  <= slots_free_q + 2'd1;
    end
  end

  // Frame start pulse, base capture, pending restart and sticky underrun
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q  <= 1'b0;
      base_q         <= '0;
      restart_pend_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      frame_start_q <= vsync_fall;
      if (vsync_fall) begin
        base_q         <= fb_base;
        restart_pend_q <= 1'b1;
      end else if (restart_c) begin
        restart_pend_q <= 1'b0;
      end
      if (underrun_evt_c)  underrun_q <= 1'b1;
      else if (restart_c)  underrun_q <= 1'b0;
    end
  end

`ifdef LFS_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating underrun event counter, cleared only by reset
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= 16'd0;
    end else if (underrun_evt_c && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  assign underrun_cnt = 16'd0;
`endif

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_slot     = rd_slot_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign busy        = busy_q;

endmodule
